instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
PC generation and IF/ID pipeline-register stage of the RV32I core. It sits directly upstream of the combinational, word-addressed instruction memory: it drives the byte address and captures the returned instruction word. It presents the instruction and its PC to decode through a valid/ready handshake. It also handles branch/jump redirects, halt requests, and fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset; must be word-aligned.
IMEM_DEPTH, 256, instruction memory size in 32-bit words; legal fetch range is 0 .. IMEM_DEPTH*4-1.
NOP_INSTR, 32'h0000_0013, value id_instr holds while invalid (addi x0,x0,0).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
imem_addr  out  32  byte address to instruction memory; always equals the pc register (combinational).
imem_instr  in  32  instruction word returned combinationally for imem_addr.
id_valid  out  1  IF/ID register holds a valid instruction.
id_ready  in  1  decode accepts id_instr/id_pc this cycle.
id_instr  out  32  registered instruction word.
id_pc  out  32  registered PC of id_instr.
redirect_valid  in  1  taken branch/jump from execute; flushes the stage.
redirect_pc  in  32  redirect target byte address.
halt_req  in  1  stop fetching (ecall/ebreak/wfi decoded).
halted  out  1  high in HALT state.
fetch_fault  out  1  sticky; high in FAULT state.
fault_pc  out  32  offending address captured on fault entry.

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, state=RUN, id_valid=0, id_instr=NOP_INSTR, id_pc=0, halted=0, fetch_fault=0, fault_pc=0. The first load happens on the first rising edge with rst=0.
- States: RUN, HALT, FAULT. halted = (state==HALT). fetch_fault = (state==FAULT).
- Load enable: load = (state==RUN) && (!id_valid || id_ready) && !redirect_valid && in_range(pc).
- On load: id_instr<=imem_instr, id_pc<=pc, id_valid<=1, pc<=pc+4.
- Throughput: one instruction per cycle when id_ready=1. Latency: address presented in cycle N, instruction valid at decode from cycle N+1.
- Consume without load (id_valid && id_ready && !load): id_valid<=0, id_instr<=NOP_INSTR.
- Stall (id_valid && !id_ready): id_instr, id_pc, and pc hold; no refetch side effects.
- pc+4 wraps modulo 2^32. Wrap cannot be reached without leaving the legal range first, so it raises a fault.
- Priority each cycle: rst > redirect_valid > FAULT hold > halt_req > load.
- Redirect (any state except FAULT):
  - id_valid<=0, id_instr<=NOP_INSTR. The in-flight instruction is dropped even if id_ready=1 in the same cycle.
  - If redirect_pc[1:0]==0: pc<=redirect_pc, state<=RUN (this also exits HALT).
  - If redirect_pc[1:0]!=0: state<=FAULT, fault_pc<=redirect_pc, pc unchanged.
- Out-of-range fetch: in RUN with pc >= IMEM_DEPTH*4 and no redirect, state<=FAULT, fault_pc<=pc, no load. The existing id register still drains normally via id_ready.
- halt_req in RUN (no redirect): state<=HALT and no load that cycle. The current id register still drains normally. In HALT, pc holds and no loads occur. halt_req while already in HALT has no effect.
- FAULT is exited only by rst. redirect_valid in FAULT is ignored. pc and fault_pc hold.
- Reset asserted mid-stall or mid-redirect returns all outputs to reset values immediately (asynchronously).

Test Plan:
- Reset, then 4 cycles with id_ready=1 and imem[0..3]=A0,A1,A2,A3 → imem_addr 0,4,8,12. id_valid rises on edge 1. id_pc/id_instr = 0/A0, 4/A1, 8/A2 on successive cycles.
- Stall: id_ready=0 for 3 cycles with id_pc=8 → id_pc=8, id_instr=A2, imem_addr=12 all held. Release id_ready → next cycle id_pc=12.
- Redirect 0x40 with id_valid=1 and id_ready=1 → next cycle id_valid=0, imem_addr=0x40. Following cycle id_pc=0x40, id_instr=imem[16].
- Misaligned redirect 0x42 → fetch_fault=1, fault_pc=0x42, id_valid=0. A later redirect to 0x10 is ignored. Only rst clears the fault.
- halt_req at pc=0x20 → halted=1, imem_addr stays 0x20, pending instruction drains. Then redirect 0x08 → halted=0, id_pc=0x08 one cycle later.
- IMEM_DEPTH=4, sequential fetch from 0 → instructions at 0,4,8,12 delivered. At pc=16: fetch_fault=1, fault_pc=0x10, no fifth id_valid.

Source files
------------

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: PC generation, IF/ID pipeline register with valid/ready
// handshake, redirect handling, halt and sticky fetch-fault states.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  // 33-bit limit so IMEM_DEPTH*4 == 2^32 cannot overflow the compare
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_DEPTH) * 33'd4;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  logic in_range;
  logic load;
  logic consume;

  assign in_range = ({1'b0, pc_q} < PC_LIMIT);
  assign consume  = id_valid_q && id_ready;
  assign load     = (state_q == ST_RUN) && (!id_valid_q || id_ready) && !redirect_valid
                    && !halt_req && in_range;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    fault_pc_d = fault_pc_q;

    if (redirect_valid && (state_q != ST_FAULT)) begin
      // Flush wins over a same-cycle consume: the in-flight word is dropped.
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d    = redirect_pc;
        state_d = ST_RUN;
      end else begin
        state_d    = ST_FAULT;
        fault_pc_d = redirect_pc;
      end
    end else begin
      if (state_q == ST_RUN) begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (!in_range) begin
          state_d    = ST_FAULT;
          fault_pc_d = pc_q;
        end
      end

      // The IF/ID register keeps draining in HALT and FAULT.
      if (load) begin
        id_instr_d = imem_instr;
        id_pc_d    = pc_q;
        id_valid_d = 1'b1;
        pc_d       = pc_q + 32'd4;
      end else if (consume) begin
        id_valid_d = 1'b0;
        id_instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= 32'd0;
      fault_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_fault = (state_q == ST_FAULT);
  assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed steps, randomized traffic against a
// behavioural fetch model, plus a small-memory instance for the range fault.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int MODE_RUN = 0, MODE_HALT = 1, MODE_FAULT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:255];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a < 32'd1024) return mem[a[9:2]];
    return 32'hDEAD_BEEF;
  endfunction

  // main instance, 256-word memory
  logic        rst, id_ready, redirect_valid, halt_req;
  logic [31:0] redirect_pc, imem_addr, imem_instr, id_instr, id_pc, fault_pc;
  logic        id_valid, halted, fetch_fault;

  assign imem_instr = mem_rd(imem_addr);

  instruction_fetch #(.IMEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .halted(halted), .fetch_fault(fetch_fault), .fault_pc(fault_pc)
  );

  // small instance, 4-word memory
  logic        rst4;
  logic [31:0] addr4, instr4, id_instr4, id_pc4, fault_pc4;
  logic        id_valid4, halted4, fault4;

  assign instr4 = mem_rd(addr4);

  instruction_fetch #(.IMEM_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst4), .imem_addr(addr4), .imem_instr(instr4),
    .id_valid(id_valid4), .id_ready(1'b1), .id_instr(id_instr4), .id_pc(id_pc4),
    .redirect_valid(1'b0), .redirect_pc(32'd0), .halt_req(1'b0),
    .halted(halted4), .fetch_fault(fault4), .fault_pc(fault_pc4)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: what decode should see after each edge.
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_idpc, m_fpc;
  logic        m_valid;

  task automatic model_reset();
    m_mode = MODE_RUN; m_pc = 32'd0; m_valid = 1'b0;
    m_instr = NOP; m_idpc = 32'd0; m_fpc = 32'd0;
  endtask

  task automatic model_step();
    logic drained, fetched;
    drained = m_valid && id_ready;
    fetched = 1'b0;
    if (redirect_valid && m_mode != MODE_FAULT) begin
      m_valid = 1'b0;
      m_instr = NOP;
      if (redirect_pc % 4 == 0) begin
        m_pc = redirect_pc;
        m_mode = MODE_RUN;
      end else begin
        m_mode = MODE_FAULT;
        m_fpc = redirect_pc;
      end
    end else begin
      if (m_mode == MODE_RUN) begin
        if (halt_req) m_mode = MODE_HALT;
        else if (m_pc >= 32'd1024) begin
          m_mode = MODE_FAULT;
          m_fpc = m_pc;
        end else if (!m_valid || id_ready) fetched = 1'b1;
      end
      if (fetched) begin
        m_instr = mem_rd(m_pc);
        m_idpc = m_pc;
        m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
      end else if (drained) begin
        m_valid = 1'b0;
        m_instr = NOP;
      end
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".imem_addr"}, imem_addr, m_pc);
    chk({where, ".id_valid"}, {31'd0, id_valid}, {31'd0, m_valid});
    chk({where, ".id_instr"}, id_instr, m_instr);
    chk({where, ".id_pc"}, id_pc, m_idpc);
    chk({where, ".halted"}, {31'd0, halted}, {31'd0, m_mode == MODE_HALT});
    chk({where, ".fetch_fault"}, {31'd0, fetch_fault}, {31'd0, m_mode == MODE_FAULT});
    chk({where, ".fault_pc"}, fault_pc, m_fpc);
  endtask

  // One clock: advance the model with the current inputs, then compare.
  task automatic tick(input string where);
    if (rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  task automatic set_in(input logic rdy, input logic rv, input logic [31:0] rpc, input logic hr);
    id_ready = rdy; redirect_valid = rv; redirect_pc = rpc; halt_req = hr;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = (i < 32) ? (32'hA000_0000 | i) : $urandom;
    rst = 1'b1; rst4 = 1'b1;
    set_in(1'b0, 1'b0, 32'd0, 1'b0);
    model_reset();
    @(posedge clk); #1;
    check_all("reset");
    chk("reset.id_instr_nop", id_instr, NOP);

    // sequential fetch, one per cycle
    rst = 1'b0;
    set_in(1'b1, 1'b0, 32'd0, 1'b0);
    tick("seq1");
    chk("seq1.pc_instr", id_instr, 32'hA000_0000);
    tick("seq2");
    tick("seq3");
    chk("seq3.id_pc", id_pc, 32'd8);
    chk("seq3.addr", imem_addr, 32'd12);

    // stall three cycles
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick("stall");
    chk("stall.id_instr", id_instr, 32'hA000_0002);
    id_ready = 1'b1;
    tick("release");
    chk("release.id_pc", id_pc, 32'd12);

    // redirect with a same-cycle consume
    set_in(1'b1, 1'b1, 32'h40, 1'b0);
    tick("redir");
    chk("redir.valid", {31'd0, id_valid}, 32'd0);
    redirect_valid = 1'b0;
    tick("redir_next");
    chk("redir_next.instr", id_instr, 32'hA000_0010);

    // halt with a pending instruction
    set_in(1'b1, 1'b1, 32'h1C, 1'b0);
    tick("pre_halt_redir");
    set_in(1'b0, 1'b0, 32'd0, 1'b0);
    tick("pre_halt_load");
    halt_req = 1'b1;
    tick("halt");
    chk("halt.addr", imem_addr, 32'h20);
    set_in(1'b1, 1'b0, 32'd0, 1'b0);
    tick("halt_drain");
    tick("halt_idle");
    chk("halt_idle.halted", {31'd0, halted}, 32'd1);
    set_in(1'b1, 1'b1, 32'h08, 1'b0);
    tick("unhalt");
    redirect_valid = 1'b0;
    tick("unhalt_next");
    chk("unhalt_next.id_pc", id_pc, 32'h08);

    // misaligned redirect, later redirect ignored
    set_in(1'b1, 1'b1, 32'h42, 1'b0);
    tick("misalign");
    redirect_pc = 32'h10;
    tick("fault_ignore");
    chk("fault_ignore.fault_pc", fault_pc, 32'h42);
    redirect_valid = 1'b0;
    rst = 1'b1;
    tick("fault_clear");
    rst = 1'b0;

    // asynchronous reset mid-stall
    set_in(1'b0, 1'b0, 32'd0, 1'b0);
    tick("pre_async");
    tick("pre_async2");
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    tick("async_hold");
    rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      rst = ((m_mode == MODE_FAULT) && ($urandom % 6 == 0)) || ($urandom % 200 == 0);
      id_ready = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 20) == 0;
      redirect_pc = ($urandom_range(0, 270) << 2) |
                    (($urandom % 10 == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      halt_req = ($urandom % 25) == 0;
      tick("rand");
    end
    rst = 1'b1;
    set_in(1'b0, 1'b0, 32'd0, 1'b0);

    // 4-word memory: four deliveries, then range fault at 0x10
    @(posedge clk); #1;
    rst4 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k <= 4) begin
        chk("small.valid", {31'd0, id_valid4}, 32'd1);
        chk("small.id_pc", id_pc4, 32'((k - 1) * 4));
        chk("small.id_instr", id_instr4, 32'hA000_0000 | 32'(k - 1));
        chk("small.fault", {31'd0, fault4}, 32'd0);
      end else begin
        chk("small.valid_end", {31'd0, id_valid4}, 32'd0);
        chk("small.fault_end", {31'd0, fault4}, 32'd1);
        chk("small.fault_pc", fault_pc4, 32'h10);
        chk("small.addr", addr4, 32'h10);
      end
    end
    chk("small.halted", {31'd0, halted4}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
